// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core and its downstream LCM stage.
package gcd_pkg;

  localparam int GCD_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per cycle, MSB first, over WIDTH cycles.
// done marks the cycle in which the final bit is produced; results are valid after that edge.
module seq_divider #(
  parameter int WIDTH = gcd_pkg::GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             q_bit;

  // quo_q doubles as the dividend shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    trial  = '0;
    diff   = '0;
    q_bit  = 1'b0;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend;
      div_d  = divisor;
    end else if (busy_q) begin
      trial = {rem_q, quo_q[WIDTH-1]};
      diff  = trial - {1'b0, div_q};
      if (trial >= {1'b0, div_q}) begin
        q_bit = 1'b1;
        rem_d = diff[WIDTH-1:0];
      end else begin
        rem_d = trial[WIDTH-1:0];
      end
      quo_d = WIDTH'({quo_q, q_bit});
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/gcd_lcm_stage.sv
// LCM stage: lcm = (x / gcd) * y via a sequential divider then a shift-add multiplier.
// One job in flight; flags gcd == 0 or a gcd that does not divide x.
module gcd_lcm_stage
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [WIDTH-1:0]   in_gcd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_lcm,
  output logic               out_err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;
  logic [2*WIDTH-1:0] lcm_q, lcm_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] acc_next;

  logic             accept;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  assign accept    = in_valid && in_ready;
  assign div_start = accept && (in_gcd != '0);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (in_x),
    .divisor   (in_gcd),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A DIV state without a running divider can never finish, so fall back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (in_gcd == '0) ? OUT : DIV;
      DIV: begin
        if (div_done)       state_d = MUL;
        else if (!div_busy) state_d = IDLE;
      end
      MUL: if (mcnt_q == LAST) state_d = OUT;
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  // Multiplier reads the finished quotient bit by bit while y shifts left.
  always_comb begin
    y_d      = y_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mcnt_d   = mcnt_q;
    lcm_d    = lcm_q;
    err_d    = err_q;
    acc_next = acc_q + (quotient[mcnt_q] ? mcand_q : '0);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          y_d = in_y;
          if (in_gcd == '0) begin
            lcm_d = '0;
            err_d = 1'b1;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          mcand_d = {{WIDTH{1'b0}}, y_q};
          acc_d   = '0;
          mcnt_d  = '0;
        end
      end
      MUL: begin
        acc_d   = acc_next;
        mcand_d = mcand_q << 1;
        mcnt_d  = mcnt_q + CNT_W'(1);
        if (mcnt_q == LAST) begin
          lcm_d = acc_next;
          err_d = (remainder != '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mcnt_q  <= '0;
      lcm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mcnt_q  <= mcnt_d;
      lcm_q   <= lcm_d;
      err_q   <= err_d;
    end
  end

  assign out_lcm = lcm_q;
  assign out_err = err_q;

endmodule
